id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- ID/EX pipeline register with integrated load-use hazard control.
- Sits between decode and the execute stage.
- Its outputs (EX register indices, operand data, control bits) feed the execute-stage operand forwarding mux and the ALU.
- Inserts bubbles on load-use hazards, holds on downstream stall, and squashes on branch flush.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 3, register index width (8 registers, no hard-wired zero register)
- ALUOP_W, 4, ALU operation code width
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal values 1..2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rqrd  in  REG_W  destination / first source register index
- id_rs  in  REG_W  second source register index
- id_uses_rqrd  in  1  instruction reads RqRd as a source
- id_uses_rs  in  1  instruction reads Rs
- id_rqrd_data  in  DATA_W  register file read data for RqRd
- id_rs_data  in  DATA_W  register file read data for Rs
- id_imm  in  DATA_W  sign-extended immediate
- id_alu_op  in  ALUOP_W  ALU operation
- id_write_en  in  1  instruction writes RqRd
- id_mem_read  in  1  load
- id_mem_write  in  1  store
- flush  in  1  branch taken in EX; squash decode
- ext_hold  in  1  downstream (memory) busy; freeze pipe
- id_stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid, ex_rqrd, ex_rs, ex_rqrd_data, ex_rs_data, ex_imm, ex_alu_op, ex_write_en, ex_mem_read, ex_mem_write  out  (widths as the id_ counterparts)  registered EX-stage copies

Behaviour:
- Reset (rst high at posedge): all ex_* outputs 0 (a bubble); FSM to RUN; bubble counter 0. id_stall is 0 while rst is high.
- Bubble: ex_valid, ex_write_en, ex_mem_read and ex_mem_write are 0; all data/index fields are 0.
- Hazard condition is combinational: ex_valid & ex_mem_read & ex_write_en & id_valid & ((id_uses_rqrd & id_rqrd==ex_rqrd) | (id_uses_rs & id_rs==ex_rqrd)).
- FSM states: RUN, STALL.
- RUN, hazard, no flush/hold:
  - id_stall=1; a bubble is loaded into EX.
  - If LOAD_USE_BUBBLES==1, stay in RUN. The load moves on, so the hazard clears next cycle.
  - Otherwise go to STALL with counter=LOAD_USE_BUBBLES-1.
- STALL: id_stall=1; a bubble is loaded; counter decrements; return to RUN when counter reaches 0 after the decrement.
- RUN, no hazard: EX <= id_* fields (id_valid=0 loads a bubble); id_stall=0.
- Priority per cycle: rst > flush > ext_hold > hazard/STALL > advance.
  - flush: EX <= bubble; FSM to RUN; counter cleared; id_stall=0. The upstream stages discard their own contents.
  - ext_hold (no flush): EX registers keep their value; FSM and counter are frozen; id_stall=1.
- Latency: one cycle from id_* to ex_*.
- No data transformation or width change: fields are copied bit-exact.
- Register 0 is ordinary; index equality alone determines a hazard.
- Write-back during a stall needs no handling here. Decode re-reads the register file every stalled cycle, and the forwarding mux covers the MEM/WB stages.
- Reset mid-stall: returns to RUN with a bubble; no pending stall survives.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - DATA_W, REG_W and ALUOP_W constants;
  - a packed id_ex_t struct for the EX field bundle;
  - constant ID_EX_BUBBLE (all zero);
  - the stall FSM state enum.
- One natural sub-module: load_use_detect, the purely combinational hazard compare. The FSM, counter and register bank stay in id_ex_pipe.

Test Plan:
- Reset with ex_* preset to non-zero values, rst high one cycle → all ex_* are 0 and id_stall=0 next cycle.
- Straight-line advance: id_rqrd=3, id_rs=5, id_rqrd_data=0x11, id_rs_data=0x22, id_alu_op=2, id_write_en=1 → next cycle ex_rqrd=3, ex_rs=5, ex_rqrd_data=0x11, ex_rs_data=0x22, ex_alu_op=2, ex_write_en=1, ex_valid=1.
- Load-use, LOAD_USE_BUBBLES=1: EX holds a load to r4; decode instruction has id_rs=4, id_uses_rs=1 → id_stall=1 for one cycle and EX becomes a bubble. The next cycle the dependent instruction enters EX with ex_rs=4, and id_stall=0.
- Load-use with LOAD_USE_BUBBLES=2 → id_stall=1 for exactly 2 cycles and two bubbles are inserted. Variant: hazard on RqRd with id_uses_rqrd=0 → no stall.
- Flush in the second cycle of a 2-bubble stall → EX is a bubble, FSM is in RUN, and id_stall=0 in the following cycle.
- ext_hold high 3 cycles with ex_rqrd_data=0xDEADBEEF → ex_* unchanged for all 3 cycles and id_stall=1. A coincident hazard resumes counting only after the hold drops.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared widths, EX field bundle and stall FSM state for the ID/EX stage
package cpu_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 3;
  localparam int ALUOP_W = 4;
  typedef enum logic {RUN, STALL} stall_state_t;
  typedef struct packed {
    logic valid;
    logic [REG_W-1:0] rqrd;
    logic [REG_W-1:0] rs;
    logic [DATA_W-1:0] rqrd_data;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] imm;
    logic [ALUOP_W-1:0] alu_op;
    logic write_en;
    logic mem_read;
    logic mem_write;
  } id_ex_t;
  localparam id_ex_t ID_EX_BUBBLE = '0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a decode instruction that reads the destination of a load sitting in EX
module load_use_detect
  import cpu_pipe_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_write_en,
  input  logic [REG_W-1:0] ex_rqrd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rqrd,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_uses_rqrd,
  input  logic             id_uses_rs,
  output logic             hazard
);
  assign hazard = ex_valid && ex_mem_read && ex_write_en && id_valid &&
                  ((id_uses_rqrd && id_rqrd == ex_rqrd) || (id_uses_rs && id_rs == ex_rqrd));
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion, hold and flush
module id_ex_pipe
  import cpu_pipe_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_W-1:0]   id_rqrd,
  input  logic [REG_W-1:0]   id_rs,
  input  logic               id_uses_rqrd,
  input  logic               id_uses_rs,
  input  logic [DATA_W-1:0]  id_rqrd_data,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_write_en,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               flush,
  input  logic               ext_hold,
  output logic               id_stall,
  output logic               ex_valid,
  output logic [REG_W-1:0]   ex_rqrd,
  output logic [REG_W-1:0]   ex_rs,
  output logic [DATA_W-1:0]  ex_rqrd_data,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_write_en,
  output logic               ex_mem_read,
  output logic               ex_mem_write
);
  id_ex_t ex, id_in;
  stall_state_t state;
  logic [1:0] cnt;
  logic hazard;
  assign id_in = '{valid: id_valid, rqrd: id_rqrd, rs: id_rs, rqrd_data: id_rqrd_data,
                   rs_data: id_rs_data, imm: id_imm, alu_op: id_alu_op,
                   write_en: id_write_en, mem_read: id_mem_read, mem_write: id_mem_write};
  assign {ex_valid, ex_rqrd, ex_rs, ex_rqrd_data, ex_rs_data, ex_imm, ex_alu_op,
          ex_write_en, ex_mem_read, ex_mem_write} = ex;
  load_use_detect u_detect (
    .ex_valid    (ex.valid),
    .ex_mem_read (ex.mem_read),
    .ex_write_en (ex.write_en),
    .ex_rqrd     (ex.rqrd),
    .id_valid    (id_valid),
    .id_rqrd     (id_rqrd),
    .id_rs       (id_rs),
    .id_uses_rqrd(id_uses_rqrd),
    .id_uses_rs  (id_uses_rs),
    .hazard      (hazard)
  );
  assign id_stall = !rst && !flush && (ext_hold || state == STALL || hazard);
  always_ff @(posedge clk)
    if (rst || flush) begin
      ex <= ID_EX_BUBBLE;
      state <= RUN;
      cnt <= '0;
    end else if (!ext_hold) begin
      ex <= (state == STALL || hazard || !id_valid) ? ID_EX_BUBBLE : id_in;
      if (state == STALL) begin
        cnt <= cnt - 2'd1;
        state <= cnt == 2'd1 ? RUN : STALL;
      end else if (hazard && LOAD_USE_BUBBLES > 1) begin
        state <= STALL;
        cnt <= 2'(LOAD_USE_BUBBLES - 1);
      end
    end
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed checks of the ID/EX register with one- and two-bubble load-use handling
module tb_id_ex_pipe;
  logic clk = 0, rst = 1;
  logic id_valid = 0, id_uses_rqrd = 0, id_uses_rs = 0, id_write_en = 0, id_mem_read = 0, id_mem_write = 0;
  logic flush = 0, ext_hold = 0;
  logic [2:0] id_rqrd = 0, id_rs = 0;
  logic [31:0] id_rqrd_data = 0, id_rs_data = 0, id_imm = 0;
  logic [3:0] id_alu_op = 0;
  logic s1, v1, we1, mr1, mw1, s2, v2, we2, mr2, mw2;
  logic [2:0] rq1, rs1, rq2, rs2;
  logic [31:0] rqd1, rsd1, im1, rqd2, rsd2, im2;
  logic [3:0] op1, op2;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  id_ex_pipe #(.LOAD_USE_BUBBLES(1)) d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rqrd(id_rqrd), .id_rs(id_rs),
    .id_uses_rqrd(id_uses_rqrd), .id_uses_rs(id_uses_rs), .id_rqrd_data(id_rqrd_data),
    .id_rs_data(id_rs_data), .id_imm(id_imm), .id_alu_op(id_alu_op), .id_write_en(id_write_en),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush), .ext_hold(ext_hold),
    .id_stall(s1), .ex_valid(v1), .ex_rqrd(rq1), .ex_rs(rs1), .ex_rqrd_data(rqd1),
    .ex_rs_data(rsd1), .ex_imm(im1), .ex_alu_op(op1), .ex_write_en(we1),
    .ex_mem_read(mr1), .ex_mem_write(mw1));
  id_ex_pipe #(.LOAD_USE_BUBBLES(2)) d2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rqrd(id_rqrd), .id_rs(id_rs),
    .id_uses_rqrd(id_uses_rqrd), .id_uses_rs(id_uses_rs), .id_rqrd_data(id_rqrd_data),
    .id_rs_data(id_rs_data), .id_imm(id_imm), .id_alu_op(id_alu_op), .id_write_en(id_write_en),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush), .ext_hold(ext_hold),
    .id_stall(s2), .ex_valid(v2), .ex_rqrd(rq2), .ex_rs(rs2), .ex_rqrd_data(rqd2),
    .ex_rs_data(rsd2), .ex_imm(im2), .ex_alu_op(op2), .ex_write_en(we2),
    .ex_mem_read(mr2), .ex_mem_write(mw2));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic instr(input logic v, input logic [2:0] rq, input logic [2:0] rs, input logic urq,
                       input logic urs, input logic [31:0] rqd, input logic [31:0] rsd,
                       input logic [31:0] imm, input logic [3:0] op, input logic we,
                       input logic mr, input logic mw);
    id_valid = v; id_rqrd = rq; id_rs = rs; id_uses_rqrd = urq; id_uses_rs = urs;
    id_rqrd_data = rqd; id_rs_data = rsd; id_imm = imm; id_alu_op = op;
    id_write_en = we; id_mem_read = mr; id_mem_write = mw;
  endtask
  function automatic logic [127:0] all1();
    return {18'd0, v1, rq1, rs1, rqd1, rsd1, im1, op1, we1, mr1, mw1};
  endfunction
  function automatic logic [127:0] all2();
    return {18'd0, v2, rq2, rs2, rqd2, rsd2, im2, op2, we2, mr2, mw2};
  endfunction
  initial begin
    tick;
    rst = 0;
    instr(1, 7, 6, 1, 1, 32'hAAAA5555, 32'h12345678, 32'h9, 5, 1, 0, 1);
    tick;
    chk("preset_valid", v1, 1);
    chk("preset_rqrd", rq2, 7);
    rst = 1;
    settle;
    chk("rst_stall1", s1, 0);
    tick;
    chk("rst_bundle1", all1(), 0);
    chk("rst_bundle2", all2(), 0);
    rst = 0;
    instr(1, 3, 5, 1, 1, 32'h11, 32'h22, 32'h33, 2, 1, 0, 0);
    settle;
    chk("adv_stall", s1, 0);
    tick;
    chk("adv_rqrd", rq1, 3);
    chk("adv_rs", rs1, 5);
    chk("adv_rqrd_data", rqd1, 32'h11);
    chk("adv_rs_data", rsd1, 32'h22);
    chk("adv_imm", im1, 32'h33);
    chk("adv_alu_op", op1, 2);
    chk("adv_we_valid", {we1, v1, mr1, mw1}, 4'b1100);
    instr(1, 4, 1, 0, 1, 32'h40, 32'h41, 32'h8, 1, 1, 1, 0);
    tick;
    chk("load_mr", {mr1, mr2, rq1, rq2}, {2'b11, 3'd4, 3'd4});
    instr(1, 2, 4, 1, 1, 32'h55, 32'h66, 32'h0, 3, 1, 0, 0);
    settle;
    chk("lu_stall_both", {s1, s2}, 2'b11);
    tick;
    chk("lu_bubble1", all1(), 0);
    chk("lu_bubble2", all2(), 0);
    chk("lu_stall_second", {s1, s2}, 2'b01);
    tick;
    chk("lu1_dep_rs", {v1, rs1}, {1'b1, 3'd4});
    chk("lu2_second_bubble", v2, 0);
    chk("lu2_stall_end", s2, 0);
    tick;
    chk("lu2_dep_rs", {v2, rs2, rsd2}, {1'b1, 3'd4, 32'h66});
    instr(1, 4, 1, 0, 1, 32'h40, 32'h41, 32'h8, 1, 1, 1, 0);
    tick;
    instr(1, 4, 0, 0, 0, 32'h77, 32'h0, 32'h0, 4, 1, 0, 0);
    settle;
    chk("nouse_stall", {s1, s2}, 2'b00);
    tick;
    chk("nouse_adv", {v2, rq2, mr2, rqd2}, {1'b1, 3'd4, 1'b0, 32'h77});
    instr(1, 4, 1, 0, 1, 32'h40, 32'h41, 32'h8, 1, 1, 1, 0);
    tick;
    instr(1, 4, 0, 1, 0, 32'h88, 32'h0, 32'h0, 4, 1, 0, 0);
    settle;
    chk("rqrd_hazard", {s1, s2}, 2'b11);
    tick;
    chk("rqrd_bubble", {v1, v2}, 2'b00);
    flush = 1;
    settle;
    chk("flush_stall", s2, 0);
    tick;
    flush = 0;
    chk("flush_bubble2", all2(), 0);
    settle;
    chk("post_flush_stall", s2, 0);
    tick;
    chk("post_flush_adv", {v2, rq2, rqd2}, {1'b1, 3'd4, 32'h88});
    instr(1, 6, 2, 0, 1, 32'hDEADBEEF, 32'h3, 32'h4, 6, 1, 1, 0);
    tick;
    ext_hold = 1;
    instr(1, 1, 6, 0, 1, 32'h99, 32'h98, 32'h0, 7, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle;
      chk("hold_stall", {s1, s2}, 2'b11);
      tick;
      chk("hold_data", {rqd1, rqd2}, {32'hDEADBEEF, 32'hDEADBEEF});
      chk("hold_ctrl", {v1, mr1, rq1, v2, mr2, rq2}, {2'b11, 3'd6, 2'b11, 3'd6});
    end
    ext_hold = 0;
    settle;
    chk("hold_hazard_stall", {s1, s2}, 2'b11);
    tick;
    chk("hold_hazard_bubble", {v1, v2}, 2'b00);
    chk("hold_hazard_stall2", {s1, s2}, 2'b01);
    tick;
    chk("hold_hazard_dep1", {v1, rs1}, {1'b1, 3'd6});
    chk("hold_hazard_bub2", v2, 0);
    tick;
    chk("hold_hazard_dep2", {v2, rs2, op2}, {1'b1, 3'd6, 4'd7});
    instr(0, 5, 5, 1, 1, 32'hFFFF, 32'hEEEE, 32'hDDDD, 9, 1, 1, 1);
    tick;
    chk("invalid_bubble1", all1(), 0);
    chk("invalid_bubble2", all2(), 0);
    instr(1, 4, 1, 0, 1, 32'h40, 32'h41, 32'h8, 1, 1, 1, 0);
    tick;
    instr(1, 2, 4, 0, 1, 32'h5, 32'h6, 32'h0, 3, 1, 0, 0);
    tick;
    chk("midstall_s2", s2, 1);
    rst = 1;
    settle;
    chk("midstall_rst_stall", s2, 0);
    tick;
    rst = 0;
    chk("midstall_rst_bubble", all2(), 0);
    settle;
    chk("midstall_after_rst", s2, 0);
    tick;
    chk("midstall_resume", {v2, rs2}, {1'b1, 3'd4});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
